// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
// ==========================================================================
// pipelined_cla_addsub : STAGES-deep carry-lookahead adder/subtractor with
// valid/ready flow control and carry/overflow/zero flags.   Revision 1.0
// ==========================================================================
module pipelined_cla_addsub #(
  parameter int BITS   = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            sub,
  input  logic            cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            overflow,
  output logic            zero
);

  localparam int NST  = (STAGES > 0) ? STAGES : 1;
  localparam int SEG  = BITS / NST;
  localparam int GRP  = (GROUP > 0) ? GROUP : 1;
  localparam int NGRP = (SEG / GRP > 0) ? SEG / GRP : 1;
  localparam int LAST = NST - 1;

  if (STAGES < 1 || GROUP < 1 || (BITS % NST) != 0 || (SEG % GRP) != 0) begin : g_bad_params
    $error("pipelined_cla_addsub: illegal BITS/GROUP/STAGES combination");
  end

  // Returns {carry into slice MSB, carry out of slice, slice sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] a_s,
                                             input logic [SEG-1:0] b_s,
                                             input logic           c_in);
    logic [SEG-1:0]  g;
    logic [SEG-1:0]  p;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   gc;
    logic [SEG:0]    c;
    logic            acc;
    logic            ap;
    g  = a_s & b_s;
    p  = a_s ^ b_s;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int q = 0; q < NGRP; q++) begin
      acc = 1'b0;
      ap  = 1'b1;
      for (int m = GRP - 1; m >= 0; m--) begin
        acc = acc | (ap & g[q*GRP+m]);
        ap  = ap & p[q*GRP+m];
      end
      gg[q] = acc;
      gp[q] = ap;
    end
    gc[0] = c_in;
    for (int q = 1; q <= NGRP; q++) begin
      acc = 1'b0;
      ap  = 1'b1;
      for (int m = q - 1; m >= 0; m--) begin
        acc = acc | (ap & gg[m]);
        ap  = ap & gp[m];
      end
      gc[q] = acc | (ap & c_in);
    end
    for (int q = 0; q < NGRP; q++) begin
      for (int j = 0; j < GRP; j++) begin
        acc = 1'b0;
        ap  = 1'b1;
        for (int m = j - 1; m >= 0; m--) begin
          acc = acc | (ap & g[q*GRP+m]);
          ap  = ap & p[q*GRP+m];
        end
        c[q*GRP+j] = acc | (ap & gc[q]);
      end
    end
    c[SEG] = gc[NGRP];
    return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [NST-1:0]  v_q, v_d;
  logic [NST-1:0]  c_q, c_d;
  logic [NST-1:0]  w_free, w_ld, w_cmsb;
  logic [BITS-1:0] a_q [NST];
  logic [BITS-1:0] a_d [NST];
  logic [BITS-1:0] b_q [NST];
  logic [BITS-1:0] b_d [NST];
  logic [BITS-1:0] s_q [NST];
  logic [BITS-1:0] s_d [NST];
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  assign in_ready  = clr_n & w_free[0];
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    logic            f;
    logic [BITS-1:0] src_a;
    logic [BITS-1:0] src_b;
    logic [BITS-1:0] src_s;
    logic            src_c;
    logic [SEG+1:0]  r;
    int              km1;
    w_free = '0;
    w_ld   = '0;
    w_cmsb = '0;
    v_d    = '0;
    c_d    = '0;
    a_d    = '{default: '0};
    b_d    = '{default: '0};
    s_d    = '{default: '0};
    // A stage is free when empty or when everything downstream can move.
    f = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      f         = ~v_q[k] | f;
      w_free[k] = f;
    end
    for (int k = 0; k < NST; k++) begin
      km1 = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src_a   = a;
        src_b   = sub ? ~b : b;
        src_c   = sub | cin;
        src_s   = '0;
        w_ld[k] = in_valid & in_ready;
      end else begin
        src_a   = a_q[km1];
        src_b   = b_q[km1];
        src_c   = c_q[km1];
        src_s   = s_q[km1];
        w_ld[k] = v_q[km1] & w_free[k];
      end
      r                      = cla_seg(src_a[k*SEG +: SEG], src_b[k*SEG +: SEG], src_c);
      a_d[k]                 = src_a;
      b_d[k]                 = src_b;
      s_d[k]                 = src_s;
      s_d[k][k*SEG +: SEG]   = r[SEG-1:0];
      c_d[k]                 = r[SEG];
      w_cmsb[k]              = r[SEG+1];
      v_d[k]                 = w_ld[k] | (v_q[k] & ~w_free[k]);
    end
    cout_d = c_d[LAST];
    ovf_d  = c_d[LAST] ^ w_cmsb[LAST];
    zero_d = (s_d[LAST] == '0);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      v_q    <= '0;
      c_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NST; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < NST; k++) begin
        if (w_ld[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (w_ld[LAST]) begin
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
`default_nettype none
// Scoreboard bench: three BITS/GROUP/STAGES configurations run side by side,
// each checked against an arithmetic reference model.
module tb_pipelined_cla_addsub;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic clk     = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   fin_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic sv, input logic cv, input int n);
    exp_t               e;
    logic [65:0]        m, ua, ub, tot;
    logic signed [65:0] sa, sb, sr, maxp;
    m  = (66'd1 << n) - 66'd1;
    ua = {2'b00, av} & m;
    ub = {2'b00, bv} & m;
    sa = $signed(ua);
    sb = $signed(ub);
    if (ua[n-1]) sa = sa - $signed(66'd1 << n);
    if (ub[n-1]) sb = sb - $signed(66'd1 << n);
    maxp = $signed((66'd1 << (n - 1)) - 66'd1);
    if (sv) begin
      tot    = ua - ub;
      e.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      tot    = ua + ub + {65'd0, cv};
      e.cout = tot[n];
      sr     = sa + sb + $signed({65'd0, cv});
    end
    e.sum     = tot[63:0] & m[63:0];
    e.ovf     = (sr > maxp) || (sr < -maxp - 66'sd1);
    e.zero    = (e.sum == 64'd0);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  function automatic logic [63:0] pick(input logic [63:0] m);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return m;
      2:       return m >> 1;
      3:       return (m >> 1) + 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic check(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %h, required %h", cfg, nm, act, req);
    end
  endtask

  task automatic fail_now(input int cfg, input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL cfg%0d %s: event did not occur within its bound", cfg, nm);
  endtask

  for (genvar c = 0; c < 3; c++) begin : g_cfg
    localparam int CB = (c == 0) ? 32 : (c == 1) ? 16 : 64;
    localparam int CG = (c == 2) ? 8 : 4;
    localparam int CS = (c == 0) ? 2 : (c == 1) ? 1 : 4;

    logic          clr_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [CB-1:0] a         = '0;
    logic [CB-1:0] b         = '0;
    logic          sub       = 1'b0;
    logic          cin       = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CB-1:0] sum;
    logic          cout;
    logic          overflow;
    logic          zero;
    exp_t          q[$];
    int            occ       = 0;
    bit            stop_rdy  = 1'b0;

    pipelined_cla_addsub #(.BITS(CB), .GROUP(CG), .STAGES(CS)) u_dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero)
    );

    task automatic issue(input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, input logic cv, input bit lat);
      exp_t e;
      a        = CB'(av);
      b        = CB'(bv);
      sub      = sv;
      cin      = cv;
      in_valid = 1'b1;
      for (int t = 0; t <= 200; t++) begin
        @(negedge clk);
        if (clr_n && in_ready) begin
          e         = model(av, bv, sv, cv, CB);
          e.acc_cyc = cyc;
          e.chk_lat = lat;
          q.push_back(e);
          break;
        end
        if (t == 200) fail_now(c, "accept");
      end
      @(posedge clk);
      #1;
    endtask

    task automatic drain();
      for (int t = 0; t <= 300; t++) begin
        if (q.size() == 0) break;
        if (t == 300) fail_now(c, "drain");
        @(posedge clk);
        #1;
      end
    endtask

    task automatic check_cleared(input string tag);
      check(c, {tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check(c, {tag, "_in_ready"},  64'(in_ready),  64'd0);
      check(c, {tag, "_sum"},       64'(sum),       64'd0);
      check(c, {tag, "_cout"},      64'(cout),      64'd0);
      check(c, {tag, "_overflow"},  64'(overflow),  64'd0);
      check(c, {tag, "_zero"},      64'(zero),      64'd0);
    endtask

    // Monitor: compares presented outputs with the scoreboard head every cycle,
    // popping on transfer, and checks in_ready against pipeline occupancy.
    always @(negedge clk) begin
      if (!clr_n) begin
        occ = 0;
      end else begin
        check(c, "in_ready", 64'(in_ready), 64'(occ < CS || out_ready));
        if (out_valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cfg%0d unexpected_output: got sum %h, required no output", c, sum);
          end else begin
            check(c, "sum",      64'(sum),      q[0].sum);
            check(c, "cout",     64'(cout),     64'(q[0].cout));
            check(c, "overflow", 64'(overflow), 64'(q[0].ovf));
            check(c, "zero",     64'(zero),     64'(q[0].zero));
            if (out_ready) begin
              if (q[0].chk_lat) check(c, "latency", 64'(cyc - q[0].acc_cyc), 64'(CS));
              void'(q.pop_front());
            end
          end
        end
        occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      end
    end

    initial begin
      logic [63:0] m;
      m = (CB == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CB) - 64'd1);
      #1 clr_n = 1'b0;
      #1 check_cleared("reset");
      @(posedge clk);
      #1 clr_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Directed, back-to-back, no backpressure: latency checked on each.
      issue(64'd4, 64'd3, 1'b0, 1'b0, 1'b1);
      issue(64'd10, 64'd11, 1'b0, 1'b0, 1'b1);
      issue(64'd3, 64'd5, 1'b1, 1'b0, 1'b1);
      issue(64'd7, 64'd7, 1'b1, 1'b0, 1'b1);
      issue(m >> 1, 64'd1, 1'b0, 1'b0, 1'b1);
      issue(m, 64'd0, 1'b0, 1'b1, 1'b1);
      issue(m >> (CB / 2), 64'd1, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      drain();

      // Output stall for three cycles in the middle of a six-op stream.
      fork
        begin
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b0;
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join_none
      for (int i = 0; i < 6; i++) issue(pick(m), pick(m), i[0], 1'($urandom_range(0, 1)), 1'b0);
      in_valid = 1'b0;
      drain();

      // Reset with operations in flight; they must never emerge.
      issue(64'h1357, 64'h2468, 1'b0, 1'b0, 1'b0);
      issue(64'h0F0F, 64'h00F0, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b0;
      clr_n    = 1'b0;
      #1 check_cleared("midreset");
      q.delete();
      @(posedge clk);
      #1 clr_n = 1'b1;
      issue(64'd5, 64'd6, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      drain();

      // Random operands, random input gaps and random output backpressure.
      fork
        begin
          while (!stop_rdy) begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join_none
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        issue(pick(m), pick(m), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      in_valid = 1'b0;
      stop_rdy = 1'b1;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain();
      @(posedge clk);
      #1 check(c, "idle_out_valid", 64'(out_valid), 64'd0);
      fin_cnt++;
    end
  end

  initial begin
    fork
      wait (fin_cnt == 3);
      begin
        #300000;
        fail_now(-1, "global_completion");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU; next generation of the single-cycle combinational 32-bit CLA.
- Splits the BITS-wide operation into STAGES registered segments, each built from GROUP-bit lookahead blocks.
- Valid/ready handshakes on both sides; produces sum, carry-out, signed overflow and zero flags.
- Sits between the operand registers and the bus result register.

Parameters:
- BITS, 32, operand/result width.
- GROUP, 4, bits per lookahead group (generate/propagate block).
- STAGES, 2, pipeline depth; each stage handles a SEG = BITS/STAGES bit slice.
- Legal values: STAGES ≥ 1, BITS % STAGES == 0, SEG % GROUP == 0. Any other value must stop elaboration with an error.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit accepts the operands this cycle.
- a  in  BITS  summand / minuend.
- b  in  BITS  summand / subtrahend.
- sub  in  1  1 = a−b, 0 = a+b+cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  BITS  result.
- cout  out  1  carry out of bit BITS−1.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (clr_n low, asynchronous):
  - All stage valid bits, sum, cout, overflow and zero clear to 0.
  - in_ready is forced 0 while clr_n is low.
  - An operation in flight is discarded and is not replayed after release.
- Operand accept: a transfer occurs on a rising edge with in_valid && in_ready.
  - Effective b is ~b when sub=1, else b.
  - Effective carry-in is 1 when sub=1, else cin.
- Stage k (0..STAGES−1):
  - Adds slice [k*SEG +: SEG] with full GROUP-bit lookahead inside the slice, using the carry registered by stage k−1 (stage 0 uses the effective carry-in).
  - Registers the slice sum and carry-out.
  - Operand slices not yet consumed are carried forward in pipeline registers; already-computed sum slices are carried forward alongside them.
- Latency: exactly STAGES cycles from accept to out_valid, when there is no backpressure.
- Throughput: one operation per cycle.
- Flags, computed in the final stage and registered together with sum:
  - cout = carry out of the MSB. For sub, cout=1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
- Flow control:
  - Each stage holds a valid bit. A stage advances when the next stage is empty or advancing.
  - Final-stage output registers hold sum/flags stable while out_valid && !out_ready.
  - in_ready = !v0 || stage 0 advancing (combinational from the stage valids and out_ready, no dependency on in_valid).
  - Bubbles collapse: a stalled output does not block upstream stages that are empty.
- Simultaneous events: acceptance, advance and output pop in the same cycle all take effect. A full pipeline with out_ready=1 sustains one op per cycle with in_ready=1.
- Ordering: results leave in acceptance order. No reordering, no drops, no duplicates.
- STAGES=1: degenerates to a single registered CLA, latency 1.
- sum/flags change only when the final stage loads. When out_valid=0 they hold their last values.

Test Plan:
- BITS=32, STAGES=2: a=4,b=3,sub=0,cin=0 -> out_valid 2 cycles later, sum=7, cout=0, overflow=0, zero=0. Then a=10,b=11 on the next cycle -> sum=21 one cycle after the first result.
- sub=1, a=3, b=5 -> sum=0xFFFFFFFE, cout=0, overflow=0. sub=1, a=7, b=7 -> sum=0, cout=1, zero=1.
- Boundaries:
  - a=0x7FFFFFFF, b=1, add -> sum=0x80000000, overflow=1, cout=0.
  - a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, overflow=0.
  - a=0x0000FFFF, b=1 -> sum=0x00010000 (carry crosses the stage boundary).
- Stream of 6 ops with out_ready held 0 for cycles 3-5 -> in_ready drops once the pipeline is full; out results held stable; all 6 results delivered in order with correct values; no loss.
- Assert clr_n low for 1 cycle while 2 ops are in flight -> out_valid=0 and outputs 0 immediately; after release, first new op appears after STAGES cycles; old ops never appear.
- Rerun the first three scenarios with (BITS=16, GROUP=4, STAGES=1) and (BITS=64, GROUP=8, STAGES=4) -> latency equals STAGES; results match a+b+cin / a−b modulo 2^BITS with correct flags.
